// File: rtl/pipeline_control_unit_pkg.sv
// Shared definitions for the pipeline control unit and the debug unit that observes it:
// FSM state encodings, the default drain length and the register-address width.
package pipeline_control_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } pcu_state_e;

  localparam int DRAIN_CYCLES_DEFAULT = 3;
  localparam int DRAIN_CNT_W          = 8;
  localparam int REG_ADDR_W           = 5;

endpackage

// File: rtl/pipeline_control_unit_hazard.sv
// Load-use hazard detector: a load in EX whose destination feeds the instruction in ID.
module hazard_detector
  import pipeline_control_unit_pkg::*;
(
  input  logic                  i_mem_read_ex,
  input  logic [REG_ADDR_W-1:0] i_rt_addr_ex,
  input  logic [REG_ADDR_W-1:0] i_rs_addr_id,
  input  logic [REG_ADDR_W-1:0] i_rt_addr_id,
  input  logic                  i_uses_rt_id,
  output logic                  o_hazard
);

  logic w_rs_match;
  logic w_rt_match;

  assign w_rs_match = (i_rt_addr_ex == i_rs_addr_id);
  assign w_rt_match = i_uses_rt_id & (i_rt_addr_ex == i_rt_addr_id);

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign o_hazard = i_mem_read_ex & (i_rt_addr_ex != '0) & (w_rs_match | w_rt_match);

endmodule

// File: rtl/pipeline_control_unit.sv
// Pipeline control unit: run/step/drain/halt sequencing, stage enables and flushes,
// and the advance-cycle counter.
module pipeline_control_unit
  import pipeline_control_unit_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_step_mode,
  input  logic                  i_step,
  input  logic                  i_clear,
  input  logic                  i_halt_id,
  input  logic                  is_MemRead_ex,
  input  logic [REG_ADDR_W-1:0] i_rt_addr_ex,
  input  logic [REG_ADDR_W-1:0] i_rs_addr_id,
  input  logic [REG_ADDR_W-1:0] i_rt_addr_id,
  input  logic                  is_uses_rt_id,
  input  logic                  is_taken,
  output logic                  os_pc_enable,
  output logic                  os_if_id_enable,
  output logic                  os_id_ex_enable,
  output logic                  os_ex_mem_enable,
  output logic                  os_mem_wb_enable,
  output logic                  os_if_id_flush,
  output logic                  os_id_ex_flush,
  output logic                  os_halted,
  output logic                  os_busy,
  output logic [31:0]           o_cycle_count
);

  localparam logic [DRAIN_CNT_W-1:0] LP_DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_CYCLES);

  pcu_state_e             r_state;
  logic                   r_step_mode;
  logic [DRAIN_CNT_W-1:0] r_drain_cnt;
  logic [31:0]            r_cycle_count;

  logic w_hazard;
  logic w_advance;
  logic w_drain_last;

  hazard_detector u_hazard_detector (
    .i_mem_read_ex (is_MemRead_ex),
    .i_rt_addr_ex  (i_rt_addr_ex),
    .i_rs_addr_id  (i_rs_addr_id),
    .i_rt_addr_id  (i_rt_addr_id),
    .i_uses_rt_id  (is_uses_rt_id),
    .o_hazard      (w_hazard)
  );

  always_comb begin
    w_advance = 1'b0;
    case (r_state)
      ST_RUN:   w_advance = 1'b1;
      ST_STEP:  w_advance = i_step;
      ST_DRAIN: w_advance = ~r_step_mode | i_step;
      default:  w_advance = 1'b0;
    endcase
  end

  // A count of 1 (or a zero-length drain) means this advance retires the last instruction.
  assign w_drain_last = (r_drain_cnt <= DRAIN_CNT_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_step_mode   <= 1'b0;
      r_drain_cnt   <= '0;
      r_cycle_count <= '0;
    end else begin
      if (w_advance && (r_cycle_count != 32'hFFFF_FFFF)) begin
        r_cycle_count <= r_cycle_count + 32'd1;
      end
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_step_mode <= i_step_mode;
            r_state     <= i_step_mode ? ST_STEP : ST_RUN;
          end
        end
        ST_RUN, ST_STEP: begin
          if (w_advance && i_halt_id && !is_taken) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= LP_DRAIN_LOAD;
          end
        end
        ST_DRAIN: begin
          if (w_advance) begin
            if (is_taken) begin
              // The HALT sat on the wrong path; resume in the latched mode.
              r_state     <= r_step_mode ? ST_STEP : ST_RUN;
              r_drain_cnt <= '0;
            end else if (w_drain_last) begin
              r_state     <= ST_HALTED;
              r_drain_cnt <= '0;
            end else begin
              r_drain_cnt <= r_drain_cnt - DRAIN_CNT_W'(1);
            end
          end
        end
        ST_HALTED: begin
          if (i_clear) begin
            r_state       <= ST_IDLE;
            r_cycle_count <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Redirect wins over drain, hazard and halt: the target must be fetched.
  always_comb begin
    os_pc_enable     = 1'b0;
    os_if_id_enable  = 1'b0;
    os_id_ex_enable  = 1'b0;
    os_ex_mem_enable = 1'b0;
    os_mem_wb_enable = 1'b0;
    os_if_id_flush   = 1'b0;
    os_id_ex_flush   = 1'b0;
    if (w_advance) begin
      os_id_ex_enable  = 1'b1;
      os_ex_mem_enable = 1'b1;
      os_mem_wb_enable = 1'b1;
      if (is_taken) begin
        os_pc_enable    = 1'b1;
        os_if_id_enable = 1'b1;
        os_if_id_flush  = 1'b1;
        os_id_ex_flush  = 1'b1;
      end else if ((r_state == ST_DRAIN) || w_hazard) begin
        os_id_ex_flush  = 1'b1;
      end else begin
        os_pc_enable    = 1'b1;
        os_if_id_enable = 1'b1;
      end
    end
  end

  assign os_halted     = (r_state == ST_HALTED);
  assign os_busy       = (r_state == ST_RUN) || (r_state == ST_STEP) || (r_state == ST_DRAIN);
  assign o_cycle_count = r_cycle_count;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Scoreboard bench for pipeline_control_unit: directed scenarios plus randomized traffic
// checked against a behavioural model of the run/step/drain/halt rules.
module tb_pipeline_control_unit;

  localparam int NDRAIN = 3;

  logic        clk;
  logic        rst;
  logic        i_start, i_step_mode, i_step, i_clear, i_halt_id;
  logic        is_MemRead_ex, is_uses_rt_id, is_taken;
  logic [4:0]  i_rt_addr_ex, i_rs_addr_id, i_rt_addr_id;
  logic        os_pc_enable, os_if_id_enable, os_id_ex_enable, os_ex_mem_enable, os_mem_wb_enable;
  logic        os_if_id_flush, os_id_ex_flush, os_halted, os_busy;
  logic [31:0] o_cycle_count;

  pipeline_control_unit #(.DRAIN_CYCLES(NDRAIN)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_start          (i_start),
    .i_step_mode      (i_step_mode),
    .i_step           (i_step),
    .i_clear          (i_clear),
    .i_halt_id        (i_halt_id),
    .is_MemRead_ex    (is_MemRead_ex),
    .i_rt_addr_ex     (i_rt_addr_ex),
    .i_rs_addr_id     (i_rs_addr_id),
    .i_rt_addr_id     (i_rt_addr_id),
    .is_uses_rt_id    (is_uses_rt_id),
    .is_taken         (is_taken),
    .os_pc_enable     (os_pc_enable),
    .os_if_id_enable  (os_if_id_enable),
    .os_id_ex_enable  (os_id_ex_enable),
    .os_ex_mem_enable (os_ex_mem_enable),
    .os_mem_wb_enable (os_mem_wb_enable),
    .os_if_id_flush   (os_if_id_flush),
    .os_id_ex_flush   (os_id_ex_flush),
    .os_halted        (os_halted),
    .os_busy          (os_busy),
    .o_cycle_count    (o_cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst_n;
    logic       start;
    logic       step_mode;
    logic       step;
    logic       clear;
    logic       halt;
    logic       memrd;
    logic [4:0] rt_ex;
    logic [4:0] rs_id;
    logic [4:0] rt_id;
    logic       uses_rt;
    logic       taken;
  } stim_t;

  typedef struct packed {
    logic [8:0]  flags; // pc, if_id, id_ex, ex_mem, mem_wb, if_id_fl, id_ex_fl, halted, busy
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Behavioural model: a named mode, a remaining-drain count and the advance counter.
  typedef enum int {M_IDLE, M_RUN, M_STEP, M_DRAIN, M_HALTED} mmode_e;
  mmode_e      m_mode;
  bit          m_stepping;
  int          m_left;
  logic [31:0] m_cnt;

  task automatic model(input stim_t s, output exp_t e);
    bit adv, haz, pc, ifid, idex, fl1, fl2;
    e = '0;
    if (!s.rst_n) begin
      m_mode = M_IDLE; m_stepping = 0; m_left = 0; m_cnt = 0;
      return;
    end
    case (m_mode)
      M_RUN:   adv = 1;
      M_STEP:  adv = s.step;
      M_DRAIN: adv = !m_stepping || s.step;
      default: adv = 0;
    endcase
    haz = s.memrd && (s.rt_ex != 0) &&
          ((s.rt_ex == s.rs_id) || (s.uses_rt && (s.rt_ex == s.rt_id)));
    pc = 0; ifid = 0; idex = 0; fl1 = 0; fl2 = 0;
    if (adv) begin
      idex = 1;
      if (s.taken) begin pc = 1; ifid = 1; fl1 = 1; fl2 = 1; end
      else if (m_mode == M_DRAIN || haz) fl2 = 1;
      else begin pc = 1; ifid = 1; end
    end
    e.flags = {pc, ifid, idex, adv, adv, fl1, fl2, (m_mode == M_HALTED),
               (m_mode == M_RUN || m_mode == M_STEP || m_mode == M_DRAIN)};
    e.cnt = m_cnt;
    if (adv && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    case (m_mode)
      M_IDLE: if (s.start) begin
        m_stepping = s.step_mode;
        m_mode = s.step_mode ? M_STEP : M_RUN;
      end
      M_RUN, M_STEP: if (adv && s.halt && !s.taken) begin
        m_mode = M_DRAIN; m_left = NDRAIN;
      end
      M_DRAIN: if (adv) begin
        if (s.taken) m_mode = m_stepping ? M_STEP : M_RUN;
        else begin
          m_left = m_left - 1;
          if (m_left <= 0) m_mode = M_HALTED;
        end
      end
      M_HALTED: if (s.clear) begin m_mode = M_IDLE; m_cnt = 0; end
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic drive(input stim_t s);
    exp_t e;
    @(negedge clk);
    #1;
    rst = s.rst_n; i_start = s.start; i_step_mode = s.step_mode; i_step = s.step;
    i_clear = s.clear; i_halt_id = s.halt; is_MemRead_ex = s.memrd;
    i_rt_addr_ex = s.rt_ex; i_rs_addr_id = s.rs_id; i_rt_addr_id = s.rt_id;
    is_uses_rt_id = s.uses_rt; is_taken = s.taken;
    model(s, e);
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle presents a full set of outputs; compare against the oldest expectation.
  initial begin
    exp_t e;
    logic [8:0] got;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {os_pc_enable, os_if_id_enable, os_id_ex_enable, os_ex_mem_enable,
               os_mem_wb_enable, os_if_id_flush, os_id_ex_flush, os_halted, os_busy};
        total++;
        if (got !== e.flags) begin
          bad++;
          $display("FAIL ctl cyc=%0d got=%b want=%b", cyc, got, e.flags);
        end
        total++;
        if (o_cycle_count !== e.cnt) begin
          bad++;
          $display("FAIL count cyc=%0d got=%0d want=%0d", cyc, o_cycle_count, e.cnt);
        end
        cyc++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s, z;
    int    waited;
    z = '0; z.rst_n = 1'b1;
    rst = 1'b0; i_start = 0; i_step_mode = 0; i_step = 0; i_clear = 0; i_halt_id = 0;
    is_MemRead_ex = 0; i_rt_addr_ex = 0; i_rs_addr_id = 0; i_rt_addr_id = 0;
    is_uses_rt_id = 0; is_taken = 0;

    // Reset, then free-run start and counting
    s = '0;
    repeat (3) drive(s);
    s = z; s.start = 1; drive(s);
    s = z; repeat (4) drive(s);
    // Load-use stall, and no stall for r0
    s = z; s.memrd = 1; s.rt_ex = 5; s.rs_id = 5; drive(s);
    s = z; drive(s);
    s = z; s.memrd = 1; s.rt_ex = 0; s.rs_id = 0; drive(s);
    s = z; s.memrd = 1; s.rt_ex = 7; s.rt_id = 7; s.uses_rt = 1; s.rs_id = 2; drive(s);
    s = z; s.memrd = 1; s.rt_ex = 7; s.rt_id = 7; s.uses_rt = 0; s.rs_id = 2; drive(s);
    // Hazard together with a taken branch
    s = z; s.memrd = 1; s.rt_ex = 5; s.rs_id = 5; s.taken = 1; drive(s);
    // Halt, drain, halted with frozen count, clear
    s = z; s.halt = 1; drive(s);
    s = z; repeat (NDRAIN + 3) drive(s);
    s = z; s.start = 1; drive(s);
    s = z; s.clear = 1; drive(s);
    s = z; repeat (2) drive(s);
    // Step mode: pulses at 10 and 20
    s = z; s.start = 1; s.step_mode = 1; drive(s);
    for (int i = 0; i < 25; i++) begin
      s = z; s.step = (i == 10 || i == 20); drive(s);
    end
    // Reset mid-drain with two drain cycles left
    s = '0; drive(s);
    s = z; s.start = 1; drive(s);
    s = z; s.halt = 1; drive(s);
    s = z; drive(s);
    s = '0; s.memrd = 1; s.rt_ex = 3; s.rs_id = 3; drive(s);
    s = z; drive(s);
    // Wrong-path halt cancelled by a taken branch in drain
    s = z; s.start = 1; drive(s);
    s = z; s.halt = 1; drive(s);
    s = z; drive(s);
    s = z; s.taken = 1; drive(s);
    s = z; repeat (3) drive(s);
    // Step-mode drain and cancel
    s = '0; drive(s);
    s = z; s.start = 1; s.step_mode = 1; drive(s);
    s = z; s.step = 1; s.halt = 1; drive(s);
    s = z; s.step_mode = 0; repeat (2) drive(s);
    s = z; s.step = 1; drive(s);
    s = z; s.step = 1; s.taken = 1; drive(s);
    s = z; s.step = 1; drive(s);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      s.rst_n     = ($urandom_range(0, 149) != 0);
      s.start     = ($urandom_range(0, 9) < 3);
      s.step_mode = $urandom_range(0, 1);
      s.step      = $urandom_range(0, 1);
      s.clear     = ($urandom_range(0, 9) < 3);
      s.halt      = ($urandom_range(0, 99) < 8);
      s.memrd     = $urandom_range(0, 1);
      s.rt_ex     = 5'($urandom_range(0, 3));
      s.rs_id     = 5'($urandom_range(0, 3));
      s.rt_id     = 5'($urandom_range(0, 3));
      s.uses_rt   = $urandom_range(0, 1);
      s.taken     = ($urandom_range(0, 99) < 15);
      drive(s);
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    #5;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_queue got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_control_unit.md
PIPELINE_CONTROL_UNIT -- requirements
Module: pipeline_control_unit

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 3: number of advance cycles needed to retire the instructions ahead of a HALT.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- i_start  in  1  level; begin execution from IDLE
- i_step_mode  in  1  1 = single-step, 0 = free run; sampled on leaving IDLE
- i_step  in  1  one-cycle pulse; grants one advance in step mode
- i_clear  in  1  pulse; HALTED -> IDLE
- i_halt_id  in  1  HALT opcode decoded in ID
- is_MemRead_ex  in  1  instruction in EX is a load
- i_rt_addr_ex  in  5  load destination in EX
- i_rs_addr_id  in  5  rs of instruction in ID
- i_rt_addr_id  in  5  rt of instruction in ID
- is_uses_rt_id  in  1  ID instruction reads rt
- is_taken  in  1  branch/jump taken, resolved in EX
- os_pc_enable, os_if_id_enable, os_id_ex_enable, os_ex_mem_enable, os_mem_wb_enable  out  1 each  register-stage write enables
- os_if_id_flush, os_id_ex_flush  out  1 each  load a bubble into the stage
- os_halted  out  1  state is HALTED
- os_busy  out  1  state is RUN, STEP or DRAIN
- o_cycle_count  out  32  advance-cycle counter

Function
REQ-003 SHALL implement FSM states IDLE, RUN, STEP, DRAIN, HALTED.
REQ-004 Transitions SHALL be:
- IDLE -> RUN when i_start=1 and i_step_mode=0
- IDLE -> STEP when i_start=1 and i_step_mode=1
- RUN/STEP -> DRAIN on an advance cycle with i_halt_id=1 and is_taken=0
- DRAIN -> HALTED after DRAIN_CYCLES advance cycles
- DRAIN -> RUN or STEP, per the latched mode, on an advance cycle with is_taken=1; the HALT was wrong-path and the drain is cancelled
- HALTED -> IDLE on i_clear
REQ-005 An advance cycle SHALL be: any cycle in RUN; a cycle in STEP with i_step=1; a cycle in DRAIN when in free-run mode, or with i_step=1 in step mode.
REQ-006 On non-advance cycles, and in IDLE and HALTED, all enables and flushes SHALL be 0.
REQ-007 On an advance cycle, os_ex_mem_enable, os_mem_wb_enable and os_id_ex_enable SHALL be 1.
REQ-008 Load-use hazard SHALL be is_MemRead_ex & (i_rt_addr_ex!=0) & ((i_rt_addr_ex==i_rs_addr_id) | (is_uses_rt_id & (i_rt_addr_ex==i_rt_addr_id))).
REQ-009 On an advance cycle with a hazard and is_taken=0, the unit SHALL drive os_pc_enable=0, os_if_id_enable=0 and os_id_ex_flush=1; the stall lasts exactly one cycle.
REQ-010 On an advance cycle with is_taken=1, the unit SHALL drive os_pc_enable=1, os_if_id_flush=1 and os_id_ex_flush=1; is_taken has priority over the hazard and over i_halt_id.
REQ-011 In DRAIN, the unit SHALL hold os_pc_enable=0 and os_if_id_enable=0, and drive os_id_ex_flush=1 on every advance cycle.
REQ-012 Otherwise, on an advance cycle, os_pc_enable and os_if_id_enable SHALL be 1 with no flushes.
REQ-013 Outputs SHALL be combinational from state and inputs.
REQ-014 o_cycle_count SHALL increment on each advance cycle, saturate at 0xFFFFFFFF, and clear on an i_clear that is accepted in HALTED.
REQ-015 The drain counter SHALL load DRAIN_CYCLES on entry to DRAIN and decrement per advance cycle; the transition to HALTED occurs on the advance cycle in which it reaches 0.
REQ-016 The mode SHALL be latched on leaving IDLE; i_step_mode changes during RUN, STEP or DRAIN are ignored.
REQ-017 i_start SHALL be ignored outside IDLE, i_clear ignored outside HALTED, and i_step ignored outside STEP/DRAIN.

Reset
REQ-018 rst=0 SHALL asynchronously force state IDLE, drain counter 0, o_cycle_count 0 and latched mode 0.
REQ-019 While rst=0, all enables, flushes, os_halted and os_busy SHALL be 0, including when reset is asserted mid-DRAIN or mid-stall.

Structure
REQ-020 FSM state encodings and the DRAIN_CYCLES default SHALL live in a shared include/header used by the debug unit.
REQ-021 The load-use comparison SHALL be a combinational sub-module hazard_detector; the FSM and counters stay in the top.

Verification
REQ-022 The bench SHALL cover:
- Reset, then i_start=1 with i_step_mode=0 -> RUN next cycle; all five enables 1; o_cycle_count counts 1,2,3...
- RUN with is_MemRead_ex=1, i_rt_addr_ex=5, i_rs_addr_id=5 -> one cycle with pc/if_id enables 0 and id_ex_flush=1; the same with i_rt_addr_ex=0 -> no stall.
- Hazard and is_taken=1 in the same cycle -> pc_enable=1, both flushes 1, no stall.
- i_halt_id=1 in RUN -> DRAIN; 3 advance cycles later os_halted=1 and o_cycle_count frozen; i_clear -> IDLE with count 0.
- Step mode: i_step pulses at cycles 10 and 20 -> enables high only in those cycles; o_cycle_count=2.
- rst=0 in DRAIN with drain counter=2 -> immediate IDLE, all outputs 0; is_taken=1 in DRAIN -> return to RUN.
